tc_collect: RTL and testbench
=============================

TC_COLLECT -- requirements
Module: tc_collect

Interface
REQ-001 Parameter: WIDTH, default 8, number of serial bits per frame (range 2..32).
REQ-002 t_clk  input  1  system clock, rising-edge active.
REQ-003 r  input  1  reset, asynchronous, active-high.
REQ-004 i  input  1  serial data, LSB first, taken from the upstream two's-complement stage output.
REQ-005 start  input  1  frame-start strobe, high on the cycle carrying bit 0.
REQ-006 out_ready  input  1  consumer accepts out_data this cycle.
REQ-007 out_valid  output  1  out_data holds a complete, unconsumed word.
REQ-008 out_data  output  WIDTH  assembled parallel word, bit 0 = first serial bit.
REQ-009 busy  output  1  frame capture in progress.
REQ-010 overrun  output  1  sticky flag: a completed frame was dropped.

Function
REQ-011 The capture FSM SHALL have two states, IDLE and SHIFT, plus a bit counter of ceil(log2(WIDTH)) bits.
REQ-012 In IDLE with start=1, the edge SHALL store i as bit 0, set the counter to 1, and enter SHIFT.
REQ-013 In IDLE with start=0, i SHALL be ignored and the state SHALL be held.
REQ-014 In SHIFT, each edge SHALL store i at bit position counter and increment the counter.
REQ-015 start asserted in SHIFT SHALL be ignored; that cycle's i SHALL be treated as an ordinary data bit.
REQ-016 The edge that samples bit WIDTH-1 SHALL return the FSM to IDLE and complete the frame.
REQ-017 busy SHALL equal (state == SHIFT).
REQ-018 On frame completion, the word SHALL load into out_data and out_valid SHALL be set, provided out_valid=0 or out_ready=1 on that edge.
REQ-019 Latency SHALL be 0 cycles after the last bit: out_valid is high in the cycle following the edge that sampled bit WIDTH-1.
REQ-020 If a frame completes while out_valid=1 and out_ready=0, the new word SHALL be discarded, out_data SHALL be held, and overrun SHALL set.
REQ-021 out_valid=1 with out_ready=1 and no completion SHALL clear out_valid on that edge.
REQ-022 Completion together with out_ready=1 SHALL keep out_valid=1 and load the new word, so back-to-back frames proceed without a gap.
REQ-023 start in IDLE on the cycle immediately after completion SHALL begin a new frame, giving a zero-bubble frame rate.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 overrun SHALL clear only on reset.

Reset
REQ-026 While r=1, the block SHALL force state=IDLE, counter=0, shift register=0, out_data=0, out_valid=0, busy=0 and overrun=0, independent of t_clk.
REQ-027 Asserting r mid-frame SHALL abandon the partial frame; after r falls, capture SHALL resume only on the next start.

Configuration
REQ-028 Macro TC_COLLECT_PARITY_EN defined: the block SHALL add output out_par (1 bit), the XOR of out_data, registered together with out_data, with a reset value of 0.
REQ-029 Macro TC_COLLECT_PARITY_EN undefined: port out_par and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-030 Shared package tc_pkg SHALL hold the default WIDTH constant, the collector state typedef (IDLE, SHIFT) and the counter width function.
REQ-031 The block SHALL be a single module with no sub-modules; the upstream complementer is instantiated beside it at the bench and top level, not inside it.

Verification (WIDTH=8, t_clk period 312 ns)
REQ-032 Serial 1,0,1,0,0,0,0,0 with start on bit 0, out_ready=1 -> out_valid pulses for one cycle after the 8th edge with out_data=0x05; busy is high for 7 cycles.
REQ-033 Upstream complementer fed 0x03 LSB-first, collector on its output -> out_data=0xFD.
REQ-034 Two back-to-back frames 0xA5 then 0x3C, out_ready=1 -> out_valid stays high across the boundary and out_data steps 0xA5 then 0x3C; overrun=0.
REQ-035 Frame 0x11 with out_ready=0, then frame 0x22 completes -> out_data stays 0x11 and overrun=1; out_ready=1 then clears out_valid.
REQ-036 r pulsed high after bit 4 of a frame, then a new frame 0x80 -> all outputs read 0 during reset, then out_data=0x80.
REQ-037 start re-asserted on bit 3 of a frame of 0xFF data -> start is ignored and out_data=0xFF after 8 bits.

Source files
------------

// File: rtl/tc_pkg.sv
`timescale 1ns/1ps
// tc_pkg: shared constants, state type and counter sizing for the serial
// frame collector.
package tc_pkg;

   // Default number of serial bits per frame.
   localparam int TC_WIDTH_DEF = 8;

   // Capture FSM states.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } tc_state_e;

   // Bits needed to index a bit position 0..width-1 (never less than one).
   function automatic int tc_cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/tc_collect.sv
`timescale 1ns/1ps
// tc_collect: serial-to-parallel frame collector. Bits arrive LSB first;
// start marks bit 0. A finished frame is presented as a parallel word behind
// a single-entry output register with a valid/ready handshake.
// Optional macro TC_COLLECT_PARITY_EN adds out_par, the XOR of out_data.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. A word
// transfers on every rising edge where both are high. While out_valid is high
// and out_ready is low, out_data (and out_par) hold steady. out_valid never
// depends combinationally on out_ready. A frame finishing while the held word
// is not being taken is dropped and raises the sticky overrun flag.
module tc_collect
   import tc_pkg::*;
#(
   parameter int WIDTH = TC_WIDTH_DEF
) (
   input  logic             t_clk,
   input  logic             r,
   input  logic             i,
   input  logic             start,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
`ifdef TC_COLLECT_PARITY_EN
   output logic             out_par,
`endif
   output logic             busy,
   output logic             overrun
);

   localparam int            CW   = tc_cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   tc_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             complete;
   logic             load;
   logic [WIDTH-1:0] word;

   // Capture FSM: next state, bit counter and shift register.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      complete    = 1'b0;
      word        = sr_q;
      word[cnt_q] = i;
      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d    = '0;
               sr_d[0] = i;
               cnt_d   = CW'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // start is deliberately ignored here; i is just the next bit.
            sr_d = word;
            if (cnt_q == LAST) begin
               complete = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output register: load on completion when the slot is free or being
   // drained this edge, otherwise drop the word and flag overrun.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      load    = 1'b0;
      if (complete) begin
         if (!valid_q || out_ready) begin
            load    = 1'b1;
            data_d  = word;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // State and output registers, cleared asynchronously by r.
   always_ff @(posedge t_clk or posedge r) begin
      if (r) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef TC_COLLECT_PARITY_EN
   logic par_q;

   // Parity of the word, captured on the same edge that loads out_data.
   always_ff @(posedge t_clk or posedge r) begin
      if (r) begin
         par_q <= 1'b0;
      end else if (load) begin
         par_q <= ^word;
      end
   end

   assign out_par = par_q;
`endif

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign busy      = (state_q == SHIFT);
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_tc_collect.sv
`timescale 1ns/1ps
// tb_tc_collect: scoreboard bench for tc_collect (WIDTH=8, 312 ns clock).
// A reference model turns each serialised word into an expected entry for a
// one-slot output buffer; a monitor checks the DUT against it every cycle.
module tb_tc_collect;
   import tc_pkg::*;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic t_clk = 1'b0;
   logic r;
   logic i;
   logic start;
   logic out_ready;
   logic out_valid;
   logic [W-1:0] out_data;
   logic busy;
   logic overrun;
`ifdef TC_COLLECT_PARITY_EN
   logic out_par;
`endif

   always #156 t_clk = ~t_clk;

   tc_collect #(.WIDTH(W)) dut (
      .t_clk     (t_clk),
      .r         (r),
      .i         (i),
      .start     (start),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
`ifdef TC_COLLECT_PARITY_EN
      .out_par   (out_par),
`endif
      .busy      (busy),
      .overrun   (overrun)
   );

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] cur_word  = '0;
   int           frame_pos = -1;
   logic         exp_valid = 1'b0;
   logic         exp_busy  = 1'b0;
   logic         exp_ovr   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: one-slot output buffer fed by whole frames. frame_pos
   // tells which bit of the current frame the bench is presenting (-1 = none).
   always @(posedge t_clk or posedge r) begin
      if (r) begin
         exp_q.delete();
         exp_valid = 1'b0;
         exp_busy  = 1'b0;
         exp_ovr   = 1'b0;
      end else begin
         exp_busy = (frame_pos >= 0) && (frame_pos < W - 1);
         if (frame_pos == W - 1) begin
            if (!exp_valid || out_ready) begin
               exp_q.push_back(cur_word);
               exp_valid = 1'b1;
            end else begin
               exp_ovr = 1'b1;
            end
         end else if (exp_valid && out_ready) begin
            exp_valid = 1'b0;
         end
      end
   end

   // Monitor: compare visible outputs on the falling edge; retire the head
   // word when the consumer takes it on the coming rising edge.
   always @(negedge t_clk) begin
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(exp_busy));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      if (exp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: valid word expected but queue empty at %0t", $time);
         end else begin
            check("out_data", 32'(out_data), 32'(exp_q[0]));
`ifdef TC_COLLECT_PARITY_EN
            check("out_par", 32'(out_par), 32'(^exp_q[0]));
`endif
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic bi, input logic bs, input int pos, input logic rdy);
      i         = bi;
      start     = bs;
      frame_pos = pos;
      out_ready = rdy;
      @(posedge t_clk);
      #1;
   endtask

   // rmode: 0 never ready, 1 always ready, 2 random, 3 ready only on last bit.
   function automatic logic pick_ready(input int rmode, input int b);
      case (rmode)
         0:       return 1'b0;
         1:       return 1'b1;
         3:       return (b == W - 1);
         default: return ($urandom_range(0, 2) != 0);
      endcase
   endfunction

   task automatic idle(input int n, input int rmode);
      for (int k = 0; k < n; k++)
         step(1'($urandom_range(0, 1)), 1'b0, -1, pick_ready(rmode, -1));
   endtask

   task automatic send_frame(input logic [W-1:0] bits, input logic [W-1:0] expect_w,
                             input int rmode, input int noise_pos, output int busy_cnt);
      busy_cnt = 0;
      cur_word = expect_w;
      for (int b = 0; b < W; b++) begin
         step(bits[b], (b == 0) || (b == noise_pos), b, pick_ready(rmode, b));
         busy_cnt += int'(busy);
      end
   endtask

   // Serial two's complementer as seen upstream: bits pass until the first 1
   // (inclusive), every later bit is inverted.
   function automatic logic [W-1:0] serial_negate(input logic [W-1:0] x);
      logic seen;
      logic [W-1:0] y;
      seen = 1'b0;
      y    = '0;
      for (int b = 0; b < W; b++) begin
         y[b] = x[b] ^ seen;
         seen = seen | x[b];
      end
      return y;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_data"}, 32'(out_data), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_overrun"}, 32'(overrun), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int bc;
      logic [W-1:0] x;
      logic [W-1:0] neg;
      logic [W-1:0] w;
      logic [W-1:0] pre;

      r = 1'b1; i = 1'b0; start = 1'b0; out_ready = 1'b0; frame_pos = -1;
      repeat (2) @(posedge t_clk);
      #1;
      check_all_zero("reset");
      r = 1'b0;
      idle(2, 1);

      // Single frame 0x05, consumer always ready; busy spans 7 cycles.
      send_frame(8'h05, 8'h05, 1, -1, bc);
      check("busy_cycles", 32'(bc), 32'd7);
      idle(2, 1);

      // Upstream complementer fed 0x03.
      x   = 8'h03;
      neg = -x;
      send_frame(serial_negate(x), neg, 1, -1, bc);
      idle(2, 1);

      // Back-to-back frames; slot drained exactly on the second completion.
      send_frame(8'hA5, 8'hA5, 0, -1, bc);
      send_frame(8'h3C, 8'h3C, 3, -1, bc);
      idle(3, 1);

      // Overrun: 0x11 held, 0x22 dropped.
      send_frame(8'h11, 8'h11, 0, -1, bc);
      send_frame(8'h22, 8'h22, 0, -1, bc);
      idle(1, 0);
      check("ovr_held_data", 32'(out_data), 32'h11);
      check("ovr_flag", 32'(overrun), 32'd1);
      idle(3, 1);
      check("ovr_sticky", 32'(overrun), 32'd1);

      // start re-asserted on bit 3 is just data.
      send_frame(8'hFF, 8'hFF, 1, 3, bc);
      idle(2, 1);

      // Reset after bit 4 of a frame, then a fresh frame 0x80.
      pre      = 8'h5A;
      cur_word = pre;
      for (int b = 0; b <= 4; b++) step(pre[b], b == 0, b, 1'b1);
      r = 1'b1; frame_pos = -1; start = 1'b0;
      #1;
      check_all_zero("midreset");
      step(1'b1, 1'b1, -1, 1'b1);
      step(1'b1, 1'b0, -1, 1'b1);
      check_all_zero("hold_reset");
      r = 1'b0;
      idle(2, 1);
      check("after_reset_busy", 32'(busy), 32'd0);
      send_frame(8'h80, 8'h80, 1, -1, bc);
      idle(2, 1);

      // Randomised frames, gaps (zero gap = back-to-back), consumer stalls
      // and stray start pulses inside frames.
      repeat (40) begin
         idle($urandom_range(0, 2), 2);
         w = W'($urandom);
         send_frame(w, w, $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : -1, bc);
      end
      idle(4, 1);
      check("drained_valid", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
